fft_result_reader: RTL and testbench

FFT_RESULT_READER -- requirements
Module: fft_result_reader

---
 rtl/fft_result_reader.sv | 251 +++++++++++++++++++++++++
 tb/tb_fft_result_reader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_result_reader.sv
// fft_result_reader
// Unloads the 1024 result bins of a finished FFT from the result RAM and
// streams them in natural order (k = 0..1023) over a valid/ready interface.
//
// Parameters
//   DATA_W : width of one packed {re,im} bin word
//   RD_LAT : result-RAM read latency in cycles (1 or 2)
//   BITREV : 1 = bin k lives at address bitrev10(k), 0 = at address k
//
// Ports
//   clk, rst_n          : clock (rising edge), synchronous active-low reset
//   start_i, bank_i     : unload request pulse and the bank holding the results
//   rd_en_o, rd_addr_o  : RAM read strobe and address
//   memsel_o            : RAM bank select (bank_i latched at start)
//   rd_data_i           : RAM read data, valid RD_LAT cycles after rd_en_o
//   m_data_o/m_index_o/m_valid_o/m_ready_i/m_last_o : output bin stream
//   busy_o, done_o      : unload in progress / one-cycle completion pulse
//
// The output stage is a small FIFO of depth RD_LAT+2 whose head entry is the
// registered m_* outputs; the remaining RD_LAT+1 entries form a backing queue.
// Reads are only issued when the data they return is guaranteed a slot.
module fft_result_reader #(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1,
    parameter int BITREV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              bank_i,
    output logic              rd_en_o,
    output logic [9:0]        rd_addr_o,
    output logic              memsel_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic [9:0]        m_index_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              m_last_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int DEPTH  = RD_LAT + 2;
    localparam int BDEPTH = RD_LAT + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [9:0] bitrev10(input logic [9:0] a);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) begin
            r[i] = a[9-i];
        end
        return r;
    endfunction

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        if (p == 2'(BDEPTH - 1)) begin
            return 2'd0;
        end else begin
            return p + 2'd1;
        end
    endfunction

    state_t              state_r, state_s;
    logic [9:0]          k_r, k_s;
    logic [9:0]          rd_idx_r, rd_idx_s;
    logic                rd_en_s, memsel_s, busy_s, done_s;
    logic [9:0]          rd_addr_s;

    // Read-return tracking: valid bit and natural index per in-flight read
    logic                pend_v_r   [RD_LAT];
    logic [9:0]          pend_idx_r [RD_LAT];

    // Backing queue behind the output head register
    logic [DATA_W-1:0]   bq_data_r [4];
    logic [9:0]          bq_idx_r  [4];
    logic [1:0]          bq_rp_r, bq_wp_r, bq_cnt_r, bq_cnt_s;
    logic                bq_push_s, bq_pop_s;

    logic                m_valid_s, m_last_s;
    logic [DATA_W-1:0]   m_data_s;
    logic [9:0]          m_index_s;

    logic                wr_s, pop_s, credit_ok_s;
    logic [9:0]          wr_idx_s;
    logic [3:0]          inflight_s, occ_s, total_s;

    assign wr_s     = pend_v_r[RD_LAT-1];
    assign wr_idx_s = pend_idx_r[RD_LAT-1];
    assign pop_s    = m_valid_o & m_ready_i;

    // Credit: everything already committed after this edge, plus one new read, must fit the FIFO
    always_comb begin
        inflight_s = {3'd0, rd_en_o};
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_s = inflight_s + {3'd0, pend_v_r[i]};
        end
        occ_s       = {3'd0, m_valid_o} + {2'd0, bq_cnt_r};
        total_s     = occ_s + inflight_s - {3'd0, pop_s};
        credit_ok_s = (total_s < 4'(DEPTH));
    end

    // FIFO steering: refill the head from the backing queue first, else straight from the RAM
    always_comb begin
        bq_push_s = 1'b0;
        bq_pop_s  = 1'b0;
        m_valid_s = m_valid_o;
        m_data_s  = m_data_o;
        m_index_s = m_index_o;
        if (!m_valid_o || pop_s) begin
            if (bq_cnt_r != 2'd0) begin
                bq_pop_s  = 1'b1;
                bq_push_s = wr_s;
                m_valid_s = 1'b1;
                m_data_s  = bq_data_r[bq_rp_r];
                m_index_s = bq_idx_r[bq_rp_r];
            end else if (wr_s) begin
                m_valid_s = 1'b1;
                m_data_s  = rd_data_i;
                m_index_s = wr_idx_s;
            end else begin
                m_valid_s = 1'b0;
                m_data_s  = '0;
                m_index_s = 10'd0;
            end
        end else begin
            bq_push_s = wr_s;
        end
        m_last_s = m_valid_s & (m_index_s == 10'd1023);
        bq_cnt_s = bq_cnt_r + {1'b0, bq_push_s} - {1'b0, bq_pop_s};
    end

    // Control FSM next state and next values of the registered read-side outputs
    always_comb begin
        state_s   = state_r;
        k_s       = k_r;
        rd_idx_s  = rd_idx_r;
        rd_en_s   = 1'b0;
        rd_addr_s = 10'd0;
        memsel_s  = memsel_o;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    // Bin 0 is issued right away so the first read lands in the next cycle
                    memsel_s  = bank_i;
                    rd_en_s   = 1'b1;
                    rd_addr_s = 10'd0;
                    rd_idx_s  = 10'd0;
                    k_s       = 10'd1;
                    state_s   = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (credit_ok_s) begin
                    rd_en_s   = 1'b1;
                    rd_addr_s = (BITREV != 0) ? bitrev10(k_r) : k_r;
                    rd_idx_s  = k_r;
                    k_s       = k_r + 10'd1;
                    if (k_r == 10'd1023) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = READ;
                    end
                end else begin
                    state_s = READ;
                end
            end
            DRAIN: begin
                if (pop_s && m_last_o) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
        done_s = (state_s == DONE);
    end

    // State, counters, read pipeline, FIFO and all outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            k_r       <= 10'd0;
            rd_idx_r  <= 10'd0;
            rd_en_o   <= 1'b0;
            rd_addr_o <= 10'd0;
            memsel_o  <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                pend_v_r[i]   <= 1'b0;
                pend_idx_r[i] <= 10'd0;
            end
            for (int i = 0; i < 4; i++) begin
                bq_data_r[i] <= '0;
                bq_idx_r[i]  <= 10'd0;
            end
            bq_rp_r   <= 2'd0;
            bq_wp_r   <= 2'd0;
            bq_cnt_r  <= 2'd0;
            m_valid_o <= 1'b0;
            m_data_o  <= '0;
            m_index_o <= 10'd0;
            m_last_o  <= 1'b0;
        end else begin
            state_r   <= state_s;
            k_r       <= k_s;
            rd_idx_r  <= rd_idx_s;
            rd_en_o   <= rd_en_s;
            rd_addr_o <= rd_addr_s;
            memsel_o  <= memsel_s;
            busy_o    <= busy_s;
            done_o    <= done_s;
            pend_v_r[0]   <= rd_en_o;
            pend_idx_r[0] <= rd_idx_r;
            for (int i = 1; i < RD_LAT; i++) begin
                pend_v_r[i]   <= pend_v_r[i-1];
                pend_idx_r[i] <= pend_idx_r[i-1];
            end
            if (bq_push_s) begin
                bq_data_r[bq_wp_r] <= rd_data_i;
                bq_idx_r[bq_wp_r]  <= wr_idx_s;
                bq_wp_r            <= ptr_inc(bq_wp_r);
            end
            if (bq_pop_s) begin
                bq_rp_r <= ptr_inc(bq_rp_r);
            end
            bq_cnt_r  <= bq_cnt_s;
            m_valid_o <= m_valid_s;
            m_data_o  <= m_data_s;
            m_index_o <= m_index_s;
            m_last_o  <= m_last_s;
        end
    end

endmodule

// File: tb/tb_fft_result_reader.sv
// Testbench for fft_result_reader. Two instances: u0 (RD_LAT=1, BITREV=1)
// and u1 (RD_LAT=2, BITREV=0), each with a RAM model returning
// {memsel, addr} in the low 11 bits after the configured latency.
module tb_fft_result_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start   [2];
    logic        bank    [2];
    logic        ready   [2];
    logic        rd_en   [2];
    logic        memsel  [2];
    logic        m_valid [2];
    logic        m_last  [2];
    logic        busy    [2];
    logic        done    [2];
    logic [9:0]  rd_addr [2];
    logic [9:0]  m_index [2];
    logic [31:0] rd_data [2];
    logic [31:0] m_data  [2];
    logic [31:0] ram1_stage;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fft_result_reader #(.DATA_W(32), .RD_LAT(1), .BITREV(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start_i(start[0]), .bank_i(bank[0]),
        .rd_en_o(rd_en[0]), .rd_addr_o(rd_addr[0]), .memsel_o(memsel[0]),
        .rd_data_i(rd_data[0]), .m_data_o(m_data[0]), .m_index_o(m_index[0]),
        .m_valid_o(m_valid[0]), .m_ready_i(ready[0]), .m_last_o(m_last[0]),
        .busy_o(busy[0]), .done_o(done[0])
    );

    fft_result_reader #(.DATA_W(32), .RD_LAT(2), .BITREV(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start_i(start[1]), .bank_i(bank[1]),
        .rd_en_o(rd_en[1]), .rd_addr_o(rd_addr[1]), .memsel_o(memsel[1]),
        .rd_data_i(rd_data[1]), .m_data_o(m_data[1]), .m_index_o(m_index[1]),
        .m_valid_o(m_valid[1]), .m_ready_i(ready[1]), .m_last_o(m_last[1]),
        .busy_o(busy[1]), .done_o(done[1])
    );

    // RAM models: garbage when not read, {bank, addr} otherwise
    always @(posedge clk) begin
        rd_data[0] <= rd_en[0] ? {21'd0, memsel[0], rd_addr[0]} : $urandom;
        ram1_stage <= rd_en[1] ? {21'd0, memsel[1], rd_addr[1]} : $urandom;
        rd_data[1] <= ram1_stage;
    end

    function automatic int brev(input int k);
        int r;
        r = 0;
        for (int i = 0; i < 10; i++) begin
            r = r * 2 + ((k >> i) & 1);
        end
        return r;
    endfunction

    function automatic int addr_of(input int u, input int k);
        return (u == 0) ? brev(k) : k;
    endfunction

    function automatic logic [31:0] exp_word(input int u, input logic b, input int k);
        return 32'(addr_of(u, k)) | (b ? 32'h0000_0400 : 32'h0000_0000);
    endfunction

    // rmode: 0 ready=1, 1 random, 2 held 0 for 100 cycles then random
    task automatic run_unload(input int u, input logic bnk, input int rmode,
                              input bit extra, input int abort_at);
        int lat, cyc, exp_idx, issued, xfers, dones, done_cyc, last_cyc;
        logic pv, pr, hs, exp_v;
        logic [42:0] pheld, cur, expb;
        logic [9:0] ea;
        lat = (u == 0) ? 1 : 2;
        start[u] = 1'b1;
        bank[u]  = bnk;
        ready[u] = (rmode == 0);
        @(negedge clk);
        start[u] = 1'b0;
        bank[u]  = ~bnk;
        cyc = 1; exp_idx = 0; issued = 0; xfers = 0; dones = 0;
        done_cyc = -1; last_cyc = -10; pv = 1'b0; pr = 1'b0; pheld = '0;
        forever begin
            if (cyc > 20000) begin
                errors++; checks++;
                $display("FAIL timeout u%0d: got beats=%0d want 1024", u, exp_idx);
                break;
            end
            cur = {m_last[u], m_index[u], m_data[u]};
            if (rmode == 0) ready[u] = 1'b1;
            else if (rmode == 2 && cyc <= 100) ready[u] = 1'b0;
            else ready[u] = 1'($urandom_range(0, 1));

            if (pv && !pr) begin
                checks++;
                if ({m_valid[u], cur} !== {1'b1, pheld}) begin
                    errors++;
                    $display("FAIL stall_hold u%0d cyc %0d: got %0h want %0h", u, cyc, {m_valid[u], cur}, {1'b1, pheld});
                end
            end
            if (rmode == 0 && done_cyc < 0) begin
                exp_v = (cyc >= lat + 2) && (cyc <= lat + 1025);
                checks++;
                if (m_valid[u] !== exp_v) begin
                    errors++;
                    $display("FAIL valid_timing u%0d cyc %0d: got %0b want %0b", u, cyc, m_valid[u], exp_v);
                end
            end
            if (rd_en[u] === 1'b1) begin
                ea = 10'(addr_of(u, issued));
                issued++;
            end else begin
                ea = 10'd0;
            end
            checks++;
            if (rd_addr[u] !== ea) begin
                errors++;
                $display("FAIL rd_addr u%0d cyc %0d: got %0h want %0h", u, cyc, rd_addr[u], ea);
            end
            checks++;
            if (issued - xfers > lat + 2 || issued > 1024) begin
                errors++;
                $display("FAIL credit u%0d cyc %0d: got outstanding %0d want <= %0d", u, cyc, issued - xfers, lat + 2);
            end
            if (rmode == 2 && cyc == 100) begin
                checks++;
                if (issued > lat + 2) begin
                    errors++;
                    $display("FAIL stall_reads u%0d: got %0d want <= %0d", u, issued, lat + 2);
                end
            end
            if (busy[u] === 1'b1) begin
                checks++;
                if (memsel[u] !== bnk) begin
                    errors++;
                    $display("FAIL memsel u%0d cyc %0d: got %0b want %0b", u, cyc, memsel[u], bnk);
                end
            end
            hs = m_valid[u] & ready[u];
            if (hs) begin
                expb = {exp_idx == 1023, 10'(exp_idx), exp_word(u, bnk, exp_idx)};
                checks++;
                if (cur !== expb) begin
                    errors++;
                    $display("FAIL beat u%0d #%0d: got %0h want %0h", u, exp_idx, cur, expb);
                end
                exp_idx++; xfers++; last_cyc = cyc;
            end
            if (done[u] === 1'b1) begin
                dones++;
                checks++;
                if (exp_idx != 1024 || cyc != last_cyc + 1) begin
                    errors++;
                    $display("FAIL done_pulse u%0d: got beats=%0d cyc=%0d want 1024 cyc=%0d", u, exp_idx, cyc, last_cyc + 1);
                end
                done_cyc = cyc;
            end else if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                checks++;
                if ({busy[u], done[u], m_valid[u]} !== 3'b000) begin
                    errors++;
                    $display("FAIL after_done u%0d: got %0b want 000", u, {busy[u], done[u], m_valid[u]});
                end
                break;
            end
            if (abort_at >= 0 && hs && exp_idx == abort_at + 1) begin
                rst_n = 1'b0;
                @(negedge clk);
                checks++;
                if ({rd_en[u], rd_addr[u], memsel[u], m_data[u], m_index[u], m_valid[u],
                     m_last[u], busy[u], done[u]} !== 58'd0) begin
                    errors++;
                    $display("FAIL abort_reset u%0d: got busy=%0b valid=%0b rd_en=%0b want all 0", u, busy[u], m_valid[u], rd_en[u]);
                end
                rst_n = 1'b1;
                ready[u] = 1'b0;
                return;
            end
            start[u] = (extra && busy[u] === 1'b1 && done_cyc < 0 && (cyc % 97) == 3);
            pv = m_valid[u]; pr = ready[u]; pheld = cur;
            @(negedge clk);
            cyc++;
        end
        start[u] = 1'b0;
        ready[u] = 1'b0;
        checks++;
        if (exp_idx != 1024 || dones != 1 || issued != 1024) begin
            errors++;
            $display("FAIL totals u%0d: got beats=%0d dones=%0d reads=%0d want 1024/1/1024", u, exp_idx, dones, issued);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start[0] = 1'b1; bank[0] = 1'b1;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if ({rd_en[u], rd_addr[u], memsel[u], m_data[u], m_index[u], m_valid[u],
                 m_last[u], busy[u], done[u]} !== 58'd0) begin
                errors++;
                $display("FAIL reset_outputs u%0d: got busy=%0b rd_en=%0b memsel=%0b want all 0", u, busy[u], rd_en[u], memsel[u]);
            end
        end
        start[0] = 1'b0; bank[0] = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy[0], rd_en[0], busy[1], rd_en[1]} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset: got %0b want 0000", {busy[0], rd_en[0], busy[1], rd_en[1]});
        end
    endtask

    task automatic test_bitrev_lat1();
        run_unload(0, 1'b0, 0, 1'b0, -1);
    endtask

    task automatic test_natural_lat2_bank1();
        run_unload(1, 1'b1, 0, 1'b0, -1);
    endtask

    task automatic test_random_ready();
        run_unload(0, 1'b1, 1, 1'b0, -1);
        run_unload(1, 1'b0, 1, 1'b0, -1);
    endtask

    task automatic test_stall_after_start();
        run_unload(0, 1'b0, 2, 1'b0, -1);
        run_unload(1, 1'b1, 2, 1'b0, -1);
    endtask

    task automatic test_reset_mid_unload();
        run_unload(0, 1'b1, 1, 1'b0, 500);
        run_unload(0, 1'b0, 0, 1'b0, -1);
    endtask

    task automatic test_start_while_busy();
        run_unload(0, 1'b1, 1, 1'b1, -1);
        run_unload(1, 1'b0, 1, 1'b1, -1);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0; bank[u] = 1'b0; ready[u] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_bitrev_lat1();
        test_natural_lat2_bank1();
        test_random_ready();
        test_stall_after_start();
        test_reset_mid_unload();
        test_start_while_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
